vec_alu_mc: RTL

//  Parametrised multi-cycle vector ALU; next generation of the 4x8-bit combinational VALU_32.

---
 rtl/vec_alu_mc.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vec_alu_mc.sv
// vec_alu_mc -- multi-cycle lane-parallel vector ALU.
//
// S and T are split into LANES signed lanes of LANE_W bits. Logic and
// add/sub/merge/splat ops finish one cycle after start. Multiply and divide
// run on a shared iterative datapath: one bit per lane per cycle for
// LANE_W cycles, then one sign-fix cycle.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high; aborts any operation in flight
//   start  in   request, sampled only while busy==0
//   FS     in   function select (latched with start)
//   SPLAT  in   lane index for splat (latched with start)
//   S, T   in   W-bit operands (latched with start)
//   busy   out  multi-cycle operation in flight
//   done   out  one-cycle pulse; VY_hi/VY_lo/div0 are valid from this cycle
//   VY_hi  out  result high word
//   VY_lo  out  result low word
//   div0   out  per-lane divide-by-zero flags from the last VDIV
//
// Handshake: a request is taken on a rising edge where start==1 and
// busy==0. Exactly one done pulse follows each accepted request. Outputs
// are registered and hold until the next done or reset. start while busy
// is dropped, and start in the done cycle is a fresh request.

module vec_alu_mc #(
  parameter int  LANE_W = 8,
  parameter int  LANES  = 4,
  localparam int W      = LANE_W * LANES,
  localparam int SPW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       FS,
  input  logic [SPW-1:0]   SPLAT,
  input  logic [W-1:0]     S,
  input  logic [W-1:0]     T,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     VY_hi,
  output logic [W-1:0]     VY_lo,
  output logic [LANES-1:0] div0
);

  localparam int L2   = 2 * LANE_W;
  localparam int HALF = LANES / 2;
  localparam int CW   = $clog2(LANE_W + 1);

  localparam logic [4:0] FS_VMUL = 5'h02;
  localparam logic [4:0] FS_VDIV = 5'h03;
  localparam logic [4:0] FS_VADD = 5'h04;
  localparam logic [4:0] FS_VSUB = 5'h05;
  localparam logic [4:0] FS_MULE = 5'h06;
  localparam logic [4:0] FS_MULO = 5'h07;
  localparam logic [4:0] FS_AND  = 5'h08;
  localparam logic [4:0] FS_OR   = 5'h09;
  localparam logic [4:0] FS_XOR  = 5'h0A;
  localparam logic [4:0] FS_MRGL = 5'h0C;
  localparam logic [4:0] FS_MRGH = 5'h0D;
  localparam logic [4:0] FS_SPLT = 5'h0E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]                 cnt_q;
  logic [4:0]                    op_q;
  logic [W-1:0]                  s_q;
  logic [LANES-1:0]              sa_q, sb_q;
  // a_q: |T| lane (multiplicand or divisor).
  // m_q: |S| lane, shifted out MSB-first; for divide, quotient bits shift in.
  // acc_q: product accumulator, or partial remainder in the low LANE_W bits.
  logic [LANES-1:0][LANE_W-1:0]  a_q, m_q, m_d;
  logic [LANES-1:0][L2-1:0]      acc_q, acc_d;
  logic [W-1:0]                  vy_hi_q, vy_lo_q;
  logic [LANES-1:0]              div0_q;
  logic                          done_q;

  logic                          is_mc;
  logic [W-1:0]                  sc_lo;
  logic [LANES-1:0][LANE_W-1:0]  rem_sh;
  logic [LANES-1:0]              ge;
  logic [LANES-1:0][L2-1:0]      prod;
  logic [LANES-1:0][LANE_W-1:0]  quo, rmd;
  logic [LANES-1:0]              dz;
  logic [W-1:0]                  fix_hi, fix_lo;

  // Two's-complement magnitude. For the most negative value the result is
  // 2^(LANE_W-1), which is still the correct unsigned magnitude.
  function automatic logic [LANE_W-1:0] mag(input logic [LANE_W-1:0] x);
    return x[LANE_W-1] ? -x : x;
  endfunction

  assign is_mc = (FS == FS_VMUL) || (FS == FS_VDIV) ||
                 (FS == FS_MULE) || (FS == FS_MULO);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && is_mc) state_d = ST_ITER;
      ST_ITER: if (cnt_q == '0)    state_d = ST_FIX;
      ST_FIX:                      state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // ------------------------------------------------- single-cycle results
  always_comb begin
    sc_lo = S;
    case (FS)
      FS_VADD: for (int i = 0; i < LANES; i++)
                 sc_lo[i*LANE_W +: LANE_W] = S[i*LANE_W +: LANE_W] + T[i*LANE_W +: LANE_W];
      FS_VSUB: for (int i = 0; i < LANES; i++)
                 sc_lo[i*LANE_W +: LANE_W] = S[i*LANE_W +: LANE_W] - T[i*LANE_W +: LANE_W];
      FS_AND:  sc_lo = S & T;
      FS_OR:   sc_lo = S | T;
      FS_XOR:  sc_lo = S ^ T;
      // Interleave: T lane j lands in lane 2j, S lane j in lane 2j+1.
      FS_MRGL: for (int j = 0; j < HALF; j++) begin
                 sc_lo[(2*j)*LANE_W   +: LANE_W] = T[j*LANE_W +: LANE_W];
                 sc_lo[(2*j+1)*LANE_W +: LANE_W] = S[j*LANE_W +: LANE_W];
               end
      FS_MRGH: for (int j = 0; j < HALF; j++) begin
                 sc_lo[(2*j)*LANE_W   +: LANE_W] = T[(j+HALF)*LANE_W +: LANE_W];
                 sc_lo[(2*j+1)*LANE_W +: LANE_W] = S[(j+HALF)*LANE_W +: LANE_W];
               end
      FS_SPLT: for (int i = 0; i < LANES; i++)
                 sc_lo[i*LANE_W +: LANE_W] = S[int'(SPLAT)*LANE_W +: LANE_W];
      default: sc_lo = S;
    endcase
  end

  // ------------------------------------------------------ iteration step
  always_comb begin
    acc_d  = acc_q;
    m_d    = m_q;
    rem_sh = '0;
    ge     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (op_q == FS_VDIV) begin
        // Restoring divide. The partial remainder stays below the divisor,
        // so its top bit is always clear and can be shifted out.
        rem_sh[i]  = {acc_q[i][LANE_W-2:0], m_q[i][LANE_W-1]};
        ge[i]      = (rem_sh[i] >= a_q[i]);
        acc_d[i]   = {{LANE_W{1'b0}}, (ge[i] ? rem_sh[i] - a_q[i] : rem_sh[i])};
        m_d[i]     = {m_q[i][LANE_W-2:0], ge[i]};
      end else begin
        // MSB-first shift-and-add multiply.
        acc_d[i]   = {acc_q[i][L2-2:0], 1'b0} +
                     (m_q[i][LANE_W-1] ? {{LANE_W{1'b0}}, a_q[i]} : '0);
        m_d[i]     = {m_q[i][LANE_W-2:0], 1'b0};
      end
    end
  end

  // ------------------------------------------------ sign fix and packing
  always_comb begin
    prod   = '0;
    quo    = '0;
    rmd    = '0;
    dz     = '0;
    fix_hi = '0;
    fix_lo = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i] = (sa_q[i] ^ sb_q[i]) ? -acc_q[i] : acc_q[i];
      dz[i]   = (a_q[i] == '0);
      // MIN / -1 needs no special case: magnitude 2^(LANE_W-1) with a
      // positive sign truncates back to MIN.
      quo[i]  = dz[i] ? '1 : ((sa_q[i] ^ sb_q[i]) ? -m_q[i] : m_q[i]);
      rmd[i]  = dz[i] ? s_q[i*LANE_W +: LANE_W]
                      : (sa_q[i] ? -acc_q[i][LANE_W-1:0] : acc_q[i][LANE_W-1:0]);
    end
    case (op_q)
      FS_VMUL: {fix_hi, fix_lo} = prod;
      FS_MULE: for (int j = 0; j < HALF; j++) fix_lo[j*L2 +: L2] = prod[2*j];
      FS_MULO: for (int j = 0; j < HALF; j++) fix_lo[j*L2 +: L2] = prod[2*j+1];
      FS_VDIV: begin
        fix_lo = quo;
        fix_hi = rmd;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      op_q    <= '0;
      s_q     <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      a_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      vy_hi_q <= '0;
      vy_lo_q <= '0;
      div0_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          op_q <= FS;
          s_q  <= S;
          if (is_mc) begin
            cnt_q <= CW'(LANE_W - 1);
            acc_q <= '0;
            for (int i = 0; i < LANES; i++) begin
              sa_q[i] <= S[i*LANE_W + LANE_W - 1];
              sb_q[i] <= T[i*LANE_W + LANE_W - 1];
              m_q[i]  <= mag(S[i*LANE_W +: LANE_W]);
              a_q[i]  <= mag(T[i*LANE_W +: LANE_W]);
            end
          end else begin
            vy_lo_q <= sc_lo;
            vy_hi_q <= '0;
            done_q  <= 1'b1;
          end
        end
        ST_ITER: begin
          acc_q <= acc_d;
          m_q   <= m_d;
          cnt_q <= cnt_q - CW'(1);
        end
        ST_FIX: begin
          vy_hi_q <= fix_hi;
          vy_lo_q <= fix_lo;
          if (op_q == FS_VDIV) div0_q <= dz;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done  = done_q;
  assign VY_hi = vy_hi_q;
  assign VY_lo = vy_lo_q;
  assign div0  = div0_q;

endmodule
